// File: rtl/frame_cfg_pkg.sv
// Shared definitions for the frame configuration writer: header layout,
// magic value and FSM state encodings.
package frame_cfg_pkg;

  // Header magic expected in the top byte of every header word.
  localparam logic [7:0] MAGIC = 8'hFA;

  // Header field offsets, counted down from the word MSB.
  localparam int HDR_FIELD_W   = 8;
  localparam int HDR_MAGIC_OFS = 0;
  localparam int HDR_COL_OFS   = 8;
  localparam int HDR_FRM_OFS   = 16;

  // FSM state encodings.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_DATA   = 3'd1;
  localparam state_t ST_SETUP  = 3'd2;
  localparam state_t ST_STROBE = 3'd3;
  localparam state_t ST_HOLD   = 3'd4;

endpackage

// File: rtl/frame_strobe_decode.sv
// Registered one-hot decoder: turns a column/frame index pair plus an enable
// into the FrameStrobe vector. Output comes straight from flops so the strobe
// is glitch-free and at most one bit is ever high.
module frame_strobe_decode
  import frame_cfg_pkg::*;
#(
  parameter int MaxFramesPerCol = 32,
  parameter int NumColumns      = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [HDR_FIELD_W-1:0]               col,
  input  logic [HDR_FIELD_W-1:0]               frame,
  input  logic                                 en,
  output logic [NumColumns*MaxFramesPerCol-1:0] strobe
);

  logic [NumColumns*MaxFramesPerCol-1:0] strobe_d;

  // Decode the index pair into a one-hot vector; all zero when disabled.
  always_comb begin
    strobe_d = '0;
    for (int c = 0; c < NumColumns; c++) begin
      for (int f = 0; f < MaxFramesPerCol; f++) begin
        strobe_d[c*MaxFramesPerCol+f] = en && (col == HDR_FIELD_W'(c)) &&
                                        (frame == HDR_FIELD_W'(f));
      end
    end
  end

  // Register the decoded strobe vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) strobe <= '0;
    else        strobe <= strobe_d;
  end

endmodule

// File: rtl/frame_config_writer.sv
// Configuration-side frame writer. Takes a header word plus NumRows data words
// over valid/ready, assembles one full-height frame on FrameData and pulses
// the single FrameStrobe bit selected by the header.
//
// Handshake: a word transfers on a rising UserCLK edge where s_valid and
// s_ready are both high. s_ready is a function of state only (high in IDLE
// and DATA, low during reset), never of s_valid; the source must hold s_data
// stable while s_valid is high and s_ready is low.
module frame_config_writer
  import frame_cfg_pkg::*;
#(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 32,
  parameter int NumRows         = 4,
  parameter int NumColumns      = 4,
  parameter int StrobeCycles    = 1
) (
  input  logic                                  UserCLK,
  input  logic                                  resetn,
  input  logic [FrameBitsPerRow-1:0]            s_data,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic                                  clr_err,
  output logic [NumRows*FrameBitsPerRow-1:0]    FrameData,
  output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
  output logic                                  busy,
  output logic                                  err_hdr,
  output logic                                  err_range,
  output logic [15:0]                           frame_count,
  output state_t                                state_dbg
);

  localparam int W  = FrameBitsPerRow;
  localparam int RW = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int SW = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;

  state_t                 state;
  logic [RW-1:0]          row_cnt;
  logic [SW-1:0]          str_cnt;
  logic [HDR_FIELD_W-1:0] col_q;
  logic [HDR_FIELD_W-1:0] frm_q;
  logic                   drop_q;
  logic [NumRows*W-1:0]   frame_data_q;

  logic [HDR_FIELD_W-1:0] hdr_magic;
  logic [HDR_FIELD_W-1:0] hdr_col;
  logic [HDR_FIELD_W-1:0] hdr_frm;
  logic                   xfer;
  logic                   hdr_ok;
  logic                   hdr_bad;
  logic                   hdr_drop;
  logic                   last_row;
  logic                   last_str;
  logic                   strobe_en;

  assign hdr_magic = s_data[W-1-HDR_MAGIC_OFS -: HDR_FIELD_W];
  assign hdr_col   = s_data[W-1-HDR_COL_OFS   -: HDR_FIELD_W];
  assign hdr_frm   = s_data[W-1-HDR_FRM_OFS   -: HDR_FIELD_W];

  assign s_ready  = resetn && ((state == ST_IDLE) || (state == ST_DATA));
  assign xfer     = s_valid && s_ready;
  assign hdr_ok   = (state == ST_IDLE) && xfer && (hdr_magic == MAGIC);
  assign hdr_bad  = (state == ST_IDLE) && xfer && (hdr_magic != MAGIC);
  assign hdr_drop = (int'(hdr_col) >= NumColumns) ||
                    (int'(hdr_frm) >= MaxFramesPerCol);
  assign last_row = (row_cnt == RW'(NumRows - 1));
  assign last_str = (str_cnt == SW'(StrobeCycles - 1));

  // The decoder registers its output, so request the strobe one cycle ahead:
  // from SETUP through the second-to-last STROBE cycle.
  assign strobe_en = (state == ST_SETUP) || ((state == ST_STROBE) && !last_str);

  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;
  assign FrameData = frame_data_q;

  // Main FSM with header latch, row counter and strobe-cycle counter.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      row_cnt <= '0;
      str_cnt <= '0;
      col_q   <= '0;
      frm_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hdr_ok) begin
            col_q   <= hdr_col;
            frm_q   <= hdr_frm;
            drop_q  <= hdr_drop;
            row_cnt <= '0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (xfer) begin
            row_cnt <= row_cnt + 1'b1;
            // A dropped frame still consumes all its words to keep alignment.
            if (last_row) state <= drop_q ? ST_IDLE : ST_SETUP;
          end
        end
        ST_SETUP: begin
          str_cnt <= '0;
          state   <= ST_STROBE;
        end
        ST_STROBE: begin
          if (last_str) state <= ST_HOLD;
          else          str_cnt <= str_cnt + 1'b1;
        end
        ST_HOLD: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Row registers: each accepted data word lands in row row_cnt.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      frame_data_q <= '0;
    end else if ((state == ST_DATA) && xfer) begin
      for (int r = 0; r < NumRows; r++) begin
        if (row_cnt == RW'(r)) frame_data_q[r*W +: W] <= s_data;
      end
    end
  end

  // Sticky error flags; a new error in the same cycle beats clr_err.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      err_hdr   <= 1'b0;
      err_range <= 1'b0;
    end else begin
      if (hdr_bad)      err_hdr <= 1'b1;
      else if (clr_err) err_hdr <= 1'b0;
      if (hdr_ok && hdr_drop) err_range <= 1'b1;
      else if (clr_err)       err_range <= 1'b0;
    end
  end

  // Saturating count of strobed frames, bumped once per HOLD.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      frame_count <= '0;
    end else if ((state == ST_HOLD) && (frame_count != 16'hFFFF)) begin
      frame_count <= frame_count + 16'd1;
    end
  end

  frame_strobe_decode #(
    .MaxFramesPerCol (MaxFramesPerCol),
    .NumColumns      (NumColumns)
  ) u_strobe_decode (
    .clk    (UserCLK),
    .rst_n  (resetn),
    .col    (col_q),
    .frame  (frm_q),
    .en     (strobe_en),
    .strobe (FrameStrobe)
  );

endmodule

// File: tb/tb_frame_config_writer.sv
// Directed bench for frame_config_writer: one instance with the default
// single-cycle strobe and one with a three-cycle strobe.
module tb_frame_config_writer;
  import frame_cfg_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic [31:0] s_data  = '0;
  logic        s_valid = 1'b0;
  logic        clr_err = 1'b0;
  int          sel     = 1;   // 1: drive dut1, 3: drive dut3

  logic s_valid1, s_valid3;
  assign s_valid1 = s_valid && (sel == 1);
  assign s_valid3 = s_valid && (sel == 3);

  // dut1 outputs
  logic         s_ready1, busy1, err_hdr1, err_range1;
  logic [127:0] frame_data1, strobe1;
  logic [15:0]  count1;
  state_t       state1;

  // dut3 outputs
  logic         s_ready3, busy3, err_hdr3, err_range3;
  logic [127:0] frame_data3, strobe3;
  logic [15:0]  count3;
  state_t       state3;

  frame_config_writer #(
    .FrameBitsPerRow(32), .MaxFramesPerCol(32), .NumRows(4),
    .NumColumns(4), .StrobeCycles(1)
  ) dut1 (
    .UserCLK(clk), .resetn(resetn), .s_data(s_data), .s_valid(s_valid1),
    .s_ready(s_ready1), .clr_err(clr_err), .FrameData(frame_data1),
    .FrameStrobe(strobe1), .busy(busy1), .err_hdr(err_hdr1),
    .err_range(err_range1), .frame_count(count1), .state_dbg(state1)
  );

  frame_config_writer #(
    .FrameBitsPerRow(32), .MaxFramesPerCol(32), .NumRows(4),
    .NumColumns(4), .StrobeCycles(3)
  ) dut3 (
    .UserCLK(clk), .resetn(resetn), .s_data(s_data), .s_valid(s_valid3),
    .s_ready(s_ready3), .clr_err(clr_err), .FrameData(frame_data3),
    .FrameStrobe(strobe3), .busy(busy3), .err_hdr(err_hdr3),
    .err_range(err_range3), .frame_count(count3), .state_dbg(state3)
  );

  // ---------------- strobe monitor ----------------
  int strobe_hits1 = 0;
  int multi_hot    = 0;
  always @(negedge clk) begin
    if (resetn) begin
      if (|strobe1) strobe_hits1++;
      if ($countones(strobe1) > 1 || $countones(strobe3) > 1) multi_hot++;
    end
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one word and wait (bounded) for it to transfer.
  task automatic send(input logic [31:0] w);
    logic rdy;
    int   waited;
    s_data  = w;
    s_valid = 1'b1;
    waited  = 0;
    forever begin
      rdy = (sel == 1) ? s_ready1 : s_ready3;
      @(posedge clk);
      #1;
      if (rdy) break;
      waited++;
      if (waited > 20) begin
        checks++;
        errors++;
        $error("FAIL send_timeout: observed=%0d expected=%0d", waited, 0);
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  logic [127:0] one = 128'd1;
  int           hits_before;

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state while resetn is low.
    tick(3);
    check("rst_ready",  128'(s_ready1), 128'd0);
    check("rst_data",   frame_data1, 128'd0);
    check("rst_strobe", strobe1, 128'd0);
    check("rst_busy",   128'(busy1), 128'd0);
    check("rst_errs",   128'({err_hdr1, err_range1}), 128'd0);
    check("rst_count",  128'(count1), 128'd0);
    resetn = 1'b1;
    tick(1);
    check("idle_ready", 128'(s_ready1), 128'd1);

    // Frame col=1 frame=3 -> bit 35.
    send(32'hFA01_0300);
    send(32'hA000_00A0); send(32'hA100_00A1);
    send(32'hA200_00A2); send(32'hA300_00A3);
    check("f1_setup_strobe", strobe1, 128'd0);
    check("f1_setup_ready",  128'(s_ready1), 128'd0);
    check("f1_setup_busy",   128'(busy1), 128'd1);
    tick(1);
    check("f1_strobe", strobe1, one << 35);
    check("f1_data", frame_data1,
          {32'hA300_00A3, 32'hA200_00A2, 32'hA100_00A1, 32'hA000_00A0});
    tick(1);
    check("f1_hold_strobe", strobe1, 128'd0);
    check("f1_hold_ready",  128'(s_ready1), 128'd0);
    tick(1);
    check("f1_done_ready", 128'(s_ready1), 128'd1);
    check("f1_count",      128'(count1), 128'd1);
    check("f1_hits",       128'(strobe_hits1), 128'd1);
    check("f1_retain", frame_data1,
          {32'hA300_00A3, 32'hA200_00A2, 32'hA100_00A1, 32'hA000_00A0});

    // Bad magic: flag set, stay idle; next good header works (col0 frame1).
    send(32'h1200_0000);
    check("bad_err_hdr", 128'(err_hdr1), 128'd1);
    check("bad_state",   128'(state1), 128'(ST_IDLE));
    send(32'hFA00_0100);
    send(32'hB0); send(32'hB1); send(32'hB2); send(32'hB3);
    tick(1);
    check("f2_strobe", strobe1, one << 1);
    check("f2_data", frame_data1, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
    tick(2);
    check("f2_count", 128'(count1), 128'd2);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("clr_err_hdr", 128'(err_hdr1), 128'd0);

    // Out-of-range column: words consumed, no strobe.
    hits_before = strobe_hits1;
    send(32'hFA04_0000);
    send(32'hC0); send(32'hC1); send(32'hC2); send(32'hC3);
    check("rng_err",   128'(err_range1), 128'd1);
    check("rng_state", 128'(state1), 128'(ST_IDLE));
    tick(4);
    check("rng_hits",  128'(strobe_hits1), 128'(hits_before));
    check("rng_count", 128'(count1), 128'd2);
    // Out-of-range frame index (32) also drops.
    send(32'hFA00_2000);
    send(32'hC4); send(32'hC5); send(32'hC6); send(32'hC7);
    tick(4);
    check("rng2_hits", 128'(strobe_hits1), 128'(hits_before));
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("clr_err_range", 128'(err_range1), 128'd0);

    // s_valid toggling: col=2 frame=5 -> bit 69.
    send(32'hFA02_0500); tick(1);
    send(32'hD0); tick(1);
    send(32'hD1); tick(1);
    send(32'hD2); tick(1);
    send(32'hD3);
    check("tog_setup_ready", 128'(s_ready1), 128'd0);
    tick(1);
    check("tog_strobe", strobe1, one << 69);
    check("tog_strobe_ready", 128'(s_ready1), 128'd0);
    check("tog_data", frame_data1, {32'hD3, 32'hD2, 32'hD1, 32'hD0});
    tick(1);
    check("tog_hold_ready", 128'(s_ready1), 128'd0);
    tick(1);
    check("tog_count", 128'(count1), 128'd3);

    // Reset in the middle of DATA.
    hits_before = strobe_hits1;
    send(32'hFA03_0700);
    send(32'hEE0); send(32'hEE1);
    check("mid_state", 128'(state1), 128'(ST_DATA));
    resetn = 1'b0;
    #1;
    check("mid_rst_data",  frame_data1, 128'd0);
    check("mid_rst_busy",  128'(busy1), 128'd0);
    check("mid_rst_ready", 128'(s_ready1), 128'd0);
    check("mid_rst_count", 128'(count1), 128'd0);
    tick(2);
    resetn = 1'b1;
    tick(3);
    check("mid_no_strobe", 128'(strobe_hits1), 128'(hits_before));
    // Fresh frame col=3 frame=31 -> bit 127.
    send(32'hFA03_1F00);
    send(32'hE0); send(32'hE1); send(32'hE2); send(32'hE3);
    tick(1);
    check("fresh_strobe", strobe1, one << 127);
    check("fresh_data", frame_data1, {32'hE3, 32'hE2, 32'hE1, 32'hE0});
    tick(2);
    check("fresh_count", 128'(count1), 128'd1);

    // Three-cycle strobe instance: col=0 frame=0 -> bit 0.
    sel = 3;
    send(32'hFA00_0000);
    send(32'h10); send(32'h11); send(32'h12); send(32'h13);
    check("s3_setup_strobe", strobe3, 128'd0);
    tick(1);
    check("s3_strobe_c1", strobe3, 128'd1);
    tick(1);
    check("s3_strobe_c2", strobe3, 128'd1);
    tick(1);
    check("s3_strobe_c3", strobe3, 128'd1);
    check("s3_strobe_ready", 128'(s_ready3), 128'd0);
    tick(1);
    check("s3_hold_strobe", strobe3, 128'd0);
    check("s3_hold_ready",  128'(s_ready3), 128'd0);
    tick(1);
    check("s3_done_ready", 128'(s_ready3), 128'd1);
    check("s3_count",      128'(count3), 128'd1);
    check("s3_data", frame_data3, {32'h13, 32'h12, 32'h11, 32'h10});

    // clr_err coincident with a new bad header: the set wins.
    clr_err = 1'b1;
    send(32'h5500_0000);
    clr_err = 1'b0;
    check("s3_err_wins", 128'(err_hdr3), 128'd1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("s3_err_clr", 128'(err_hdr3), 128'd0);

    check("one_hot", 128'(multi_hot), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
